axilm_rd_mo: RTL and testbench
==============================

AXILM_RD_MO -- requirements
Module: axilm_rd_mo

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning ARADDR/BUS_ADDR width (legal 12..64).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning RDATA/BUS_RDATA width (legal 32 or 64).
REQ-003 The block SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of reads in flight (legal 1..16) and the response FIFO depth.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have ARESETn, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have AR channel ports: ARADDR out ADDR_W; ARPROT out 3, tied to 3'b000; ARVALID out 1; ARREADY in 1.
REQ-007 The block SHALL have R channel ports: RDATA in DATA_W; RRESP in 2; RVALID in 1; RREADY out 1.
REQ-008 The block SHALL have local request ports: BUS_ENA in 1 (read request); BUS_ADDR in ADDR_W; BUS_ACK out 1 (request accepted this cycle).
REQ-009 The block SHALL have local response ports: BUS_RVALID out 1; BUS_RDATA out DATA_W; BUS_RRESP out 2; BUS_RREADY in 1.
REQ-010 The block SHALL have ERR_CNT, out, 16, the count of responses with error status (see Configuration).

Function
REQ-011 Credit rule: the outstanding counter SHALL be +1 on each request acceptance and -1 on each local pop (BUS_RVALID & BUS_RREADY); on a simultaneous accept and pop it SHALL be unchanged.
REQ-012 The AR FSM SHALL have states IDLE (ARVALID=0) and ADDR_PEND (ARVALID=1).
REQ-013 BUS_ACK SHALL be combinational: BUS_ENA & (outstanding < MAX_OUTST) & (state==IDLE | ARREADY).
REQ-014 On BUS_ACK, the block SHALL capture ARADDR<=BUS_ADDR and enter ADDR_PEND next cycle, which permits back-to-back issue when ARREADY=1.
REQ-015 In ADDR_PEND with ARREADY=1 and no new accept, the FSM SHALL return to IDLE; with ARREADY=0, ARADDR and ARVALID SHALL hold stable.
REQ-016 A pending-R counter (AR handshakes minus R handshakes) SHALL be kept; RREADY SHALL be registered-equivalent to (pending-R != 0), and stray RVALID with pending-R==0 SHALL be ignored.
REQ-017 Each R handshake SHALL push {RRESP,RDATA} into a MAX_OUTST-deep FIFO; the credit rule guarantees no overflow.
REQ-018 The FIFO SHALL be show-ahead: BUS_RVALID = FIFO not empty; BUS_RDATA/BUS_RRESP = head entry, held stable while BUS_RRESP&~BUS_RREADY... more precisely, the head entry SHALL be held stable while BUS_RVALID & ~BUS_RREADY.
REQ-019 There SHALL be no bypass: a push into an empty FIFO is visible the next cycle, and push and pop in the same cycle are both honoured.
REQ-020 Minimum latency SHALL be: accept at cycle 0, ARVALID at 1, RVALID at 2 (slave permitting), BUS_RVALID at 3.
REQ-021 Responses SHALL be returned in issue order, with RRESP passed through unmodified.
REQ-022 FIFO pointers SHALL wrap modulo MAX_OUTST, with full/empty derived from the occupancy count.

Reset
REQ-023 On ARESETn low, the block SHALL asynchronously clear: ARVALID=0, ARADDR=0, RREADY=0, BUS_RVALID=0, BUS_RDATA=0, BUS_RRESP=0, ERR_CNT=0, all counters and pointers=0, state=IDLE.
REQ-024 A reset mid-operation SHALL discard all in-flight reads and buffered responses.
REQ-025 BUS_ACK SHALL be 0 while ARESETn is low.

Configuration
REQ-026 With macro AXILM_RD_ERR_CNT_EN defined, ERR_CNT SHALL increment on each R handshake with RRESP[1]=1, saturate at 16'hFFFF, and clear only on reset.
REQ-027 Without AXILM_RD_ERR_CNT_EN, ERR_CNT SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-028 Single read: BUS_ENA with addr 0x100, ARREADY=1, RVALID 1 cycle later with RDATA=0xCAFEF00D, RRESP=00 -> BUS_RVALID at cycle 3 with 0xCAFEF00D/00, outstanding back to 0.
REQ-029 Credit limit (MAX_OUTST=4): BUS_ENA held, ARREADY=1, no RVALID -> exactly 4 BUS_ACK pulses, ARADDRs 0x0/0x4/0x8/0xC, then BUS_ACK=0 until a pop occurs.
REQ-030 AR backpressure: ARREADY=0 for 5 cycles -> ARADDR/ARVALID stable, BUS_ACK=0; ARREADY=1 -> next request accepted the same cycle.
REQ-031 Local backpressure: 4 responses D0..D3 with BUS_RREADY=0, then BUS_RREADY=1 -> D0..D3 delivered in order on consecutive cycles, head stable while stalled.
REQ-032 Error count (macro defined): 3 responses with RRESP=10,11,00 -> ERR_CNT=2; without macro -> ERR_CNT=0.
REQ-033 Reset mid-flight: assert ARESETn low with 2 reads outstanding -> all outputs at reset values; after release, a new read completes normally and late RVALID is ignored.

Source files
------------

// File: rtl/axilm_rd_mo.sv
// AXI4-Lite read master with up to MAX_OUTST reads in flight and a show-ahead response FIFO.
// Optional macro AXILM_RD_ERR_CNT_EN enables a saturating count of error responses on ERR_CNT.
module axilm_rd_mo #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   // AR channel
   output logic [ADDR_W-1:0] ARADDR,
   output logic [2:0]        ARPROT,
   output logic              ARVALID,
   input  logic              ARREADY,
   // R channel
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RVALID,
   output logic              RREADY,
   // local request
   input  logic              BUS_ENA,
   input  logic [ADDR_W-1:0] BUS_ADDR,
   output logic              BUS_ACK,
   // local response
   output logic              BUS_RVALID,
   output logic [DATA_W-1:0] BUS_RDATA,
   output logic [1:0]        BUS_RRESP,
   input  logic              BUS_RREADY,
   output logic [15:0]       ERR_CNT
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

   typedef enum logic {
      IDLE      = 1'b0,
      ADDR_PEND = 1'b1
   } ar_state_t;

   ar_state_t         state_reg, state_next;
   logic              bus_ack;
   logic [ADDR_W-1:0] araddr_reg;
   logic [CNT_W-1:0]  outst_reg, outst_next;
   logic [CNT_W-1:0]  pend_reg, pend_next;
   logic              rready_reg;
   logic [CNT_W-1:0]  fifo_cnt_reg, fifo_cnt_next;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [DATA_W+1:0] mem_reg [MAX_OUTST];
   logic [DATA_W+1:0] head;
   logic              ar_hs, r_hs, push, pop, fifo_nempty;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign ar_hs       = (state_reg == ADDR_PEND) & ARREADY;
   assign r_hs        = RVALID & rready_reg;
   assign push        = r_hs;
   assign fifo_nempty = (fifo_cnt_reg != '0);
   assign pop         = fifo_nempty & BUS_RREADY;

   // Accept is held off while in reset so nothing leaks out before the counters are valid.
   always_comb begin
      state_next = state_reg;
      bus_ack    = ARESETn & BUS_ENA & (outst_reg < MAX_CNT) &
                   ((state_reg == IDLE) | ARREADY);
      case (state_reg)
         IDLE:      if (bus_ack) state_next = ADDR_PEND;
         ADDR_PEND: if (!bus_ack && ARREADY) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)     araddr_reg <= '0;
      else if (bus_ack) araddr_reg <= BUS_ADDR;
   end

   always_comb begin
      outst_next = outst_reg;
      case ({bus_ack, pop})
         2'b10:   outst_next = outst_reg + CNT_W'(1);
         2'b01:   outst_next = outst_reg - CNT_W'(1);
         default: outst_next = outst_reg;
      endcase
      pend_next = pend_reg;
      case ({ar_hs, r_hs})
         2'b10:   pend_next = pend_reg + CNT_W'(1);
         2'b01:   pend_next = pend_reg - CNT_W'(1);
         default: pend_next = pend_reg;
      endcase
      fifo_cnt_next = fifo_cnt_reg;
      case ({push, pop})
         2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
         2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
         default: fifo_cnt_next = fifo_cnt_reg;
      endcase
   end

   // RREADY is a register tracking whether any AR is still waiting for its R beat.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         outst_reg    <= '0;
         pend_reg     <= '0;
         rready_reg   <= 1'b0;
         fifo_cnt_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         outst_reg    <= outst_next;
         pend_reg     <= pend_next;
         rready_reg   <= (pend_next != '0);
         fifo_cnt_reg <= fifo_cnt_next;
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
   end

   // Storage has no reset; the empty flag masks stale contents on the outputs.
   always_ff @(posedge ACLK) begin
      if (push) mem_reg[wr_ptr_reg] <= {RRESP, RDATA};
   end

   assign head       = mem_reg[rd_ptr_reg];
   assign BUS_RVALID = fifo_nempty;
   assign BUS_RDATA  = fifo_nempty ? head[DATA_W-1:0] : '0;
   assign BUS_RRESP  = fifo_nempty ? head[DATA_W+1:DATA_W] : 2'b00;
   assign BUS_ACK    = bus_ack;
   assign ARADDR     = araddr_reg;
   assign ARVALID    = (state_reg == ADDR_PEND);
   assign ARPROT     = 3'b000;
   assign RREADY     = rready_reg;

`ifdef AXILM_RD_ERR_CNT_EN
   logic [15:0] err_cnt_reg;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)
         err_cnt_reg <= 16'h0000;
      else if (r_hs && RRESP[1] && (err_cnt_reg != 16'hFFFF))
         err_cnt_reg <= err_cnt_reg + 16'd1;
   end

   assign ERR_CNT = err_cnt_reg;
`else
   assign ERR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_axilm_rd_mo.sv
// Bench for axilm_rd_mo: queue-based transaction model checked every cycle, plus directed literal checks.
module tb_axilm_rd_mo;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 4;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b0;
   logic [AW-1:0] ARADDR;
   logic [2:0]    ARPROT;
   logic          ARVALID;
   logic          ARREADY = 1'b0;
   logic [DW-1:0] RDATA = '0;
   logic [1:0]    RRESP = 2'b00;
   logic          RVALID = 1'b0;
   logic          RREADY;
   logic          BUS_ENA = 1'b0;
   logic [AW-1:0] BUS_ADDR = '0;
   logic          BUS_ACK;
   logic          BUS_RVALID;
   logic [DW-1:0] BUS_RDATA;
   logic [1:0]    BUS_RRESP;
   logic          BUS_RREADY = 1'b0;
   logic [15:0]   ERR_CNT;

   int n_cmp = 0;
   int n_err = 0;

   axilm_rd_mo #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .BUS_ENA(BUS_ENA), .BUS_ADDR(BUS_ADDR), .BUS_ACK(BUS_ACK),
      .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA), .BUS_RRESP(BUS_RRESP),
      .BUS_RREADY(BUS_RREADY), .ERR_CNT(ERR_CNT)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: requests waiting for AR, count of ARs awaiting R, visible responses.
   logic [AW-1:0]   q_ar   [$];
   logic [DW+1:0]   q_fifo [$];
   int              pend_r   = 0;
   int              inflight = 0;
   int              err_m    = 0;

   always @(negedge ACLK) begin
      logic ack_e, arhs_e, rhs_e, pop_e;
      chk("arprot", ARPROT, 3'b000);
      if (!ARESETn) begin
         q_ar.delete();
         q_fifo.delete();
         pend_r   = 0;
         inflight = 0;
         err_m    = 0;
         chk("rst_arvalid", ARVALID, 0);
         chk("rst_araddr", ARADDR, 0);
         chk("rst_rready", RREADY, 0);
         chk("rst_bus_rvalid", BUS_RVALID, 0);
         chk("rst_bus_rdata", BUS_RDATA, 0);
         chk("rst_bus_rresp", BUS_RRESP, 0);
         chk("rst_err_cnt", ERR_CNT, 0);
         chk("rst_bus_ack", BUS_ACK, 0);
      end else begin
         ack_e  = BUS_ENA && (inflight < MO) && (q_ar.size() == 0 || ARREADY);
         arhs_e = (q_ar.size() != 0) && ARREADY;
         rhs_e  = (pend_r != 0) && RVALID;
         pop_e  = (q_fifo.size() != 0) && BUS_RREADY;
         chk("m_bus_ack", BUS_ACK, ack_e);
         chk("m_arvalid", ARVALID, q_ar.size() != 0);
         if (q_ar.size() != 0) chk("m_araddr", ARADDR, q_ar[0]);
         chk("m_rready", RREADY, pend_r != 0);
         chk("m_bus_rvalid", BUS_RVALID, q_fifo.size() != 0);
         if (q_fifo.size() != 0) begin
            chk("m_bus_rdata", BUS_RDATA, q_fifo[0][DW-1:0]);
            chk("m_bus_rresp", BUS_RRESP, q_fifo[0][DW+1:DW]);
         end
`ifdef AXILM_RD_ERR_CNT_EN
         chk("m_err_cnt", ERR_CNT, err_m);
`else
         chk("m_err_cnt", ERR_CNT, 0);
`endif
         if (arhs_e) begin
            void'(q_ar.pop_front());
            pend_r++;
         end
         if (ack_e) begin
            q_ar.push_back(BUS_ADDR);
            inflight++;
            $display("accept addr=0x%08h", BUS_ADDR);
         end
         if (pop_e) begin
            $display("deliver data=0x%08h resp=%0d", q_fifo[0][DW-1:0], q_fifo[0][DW+1:DW]);
            void'(q_fifo.pop_front());
            inflight--;
         end
         if (rhs_e) begin
            pend_r--;
            q_fifo.push_back({RRESP, RDATA});
            if (RRESP[1] && err_m < 65535) err_m++;
         end
      end
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] d [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
   logic [1:0]    r [4] = '{2'b10, 2'b11, 2'b00, 2'b00};
   logic [AW-1:0] ar_seen [8];
   int            acks;
   int            nar;

   initial begin
      repeat (3) step();
      ARESETn = 1'b1;
      step();

      // single read: minimum latency
      BUS_ENA = 1'b1; BUS_ADDR = 32'h100; ARREADY = 1'b1;
      @(negedge ACLK); chk("t1_ack", BUS_ACK, 1);
      step(); BUS_ENA = 1'b0;
      @(negedge ACLK); chk("t1_arvalid", ARVALID, 1); chk("t1_araddr", ARADDR, 32'h100);
      step(); RVALID = 1'b1; RDATA = 32'hCAFEF00D; RRESP = 2'b00;
      @(negedge ACLK); chk("t1_rready", RREADY, 1); chk("t1_not_yet", BUS_RVALID, 0);
      step(); RVALID = 1'b0; BUS_RREADY = 1'b1;
      @(negedge ACLK); chk("t1_bus_rvalid", BUS_RVALID, 1);
      chk("t1_bus_rdata", BUS_RDATA, 32'hCAFEF00D); chk("t1_bus_rresp", BUS_RRESP, 0);
      step();
      @(negedge ACLK); chk("t1_empty", BUS_RVALID, 0);
      step();

      // credit limit
      BUS_RREADY = 1'b0; ARREADY = 1'b1; BUS_ENA = 1'b1; BUS_ADDR = '0;
      acks = 0; nar = 0;
      repeat (10) begin
         @(negedge ACLK);
         if (BUS_ACK) acks++;
         if (ARVALID && ARREADY && nar < 8) begin
            ar_seen[nar] = ARADDR;
            nar++;
         end
         step();
         BUS_ADDR = 32'(acks * 4);
      end
      chk("t2_ack_pulses", acks, 4);
      chk("t2_ar_count", nar, 4);
      for (int i = 0; i < 4; i++) chk("t2_araddr_seq", ar_seen[i], 32'(i * 4));

      // four responses buffered under local backpressure, BUS_ENA still high
      for (int i = 0; i < 4; i++) begin
         RVALID = 1'b1; RDATA = d[i]; RRESP = r[i];
         @(negedge ACLK); chk("t4_rready", RREADY, 1); chk("t4_no_ack", BUS_ACK, 0);
         step();
      end
      RVALID = 1'b0;
      repeat (3) begin
         @(negedge ACLK);
         chk("t4_stall_valid", BUS_RVALID, 1); chk("t4_stall_head", BUS_RDATA, 32'h1111_1111);
         chk("t4_stall_no_ack", BUS_ACK, 0);
         step();
      end
`ifdef AXILM_RD_ERR_CNT_EN
      chk("t5_err_cnt", ERR_CNT, 2);
`else
      chk("t5_err_cnt", ERR_CNT, 0);
`endif
      BUS_ENA = 1'b0; BUS_RREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk("t4_drain_valid", BUS_RVALID, 1);
         chk("t4_drain_data", BUS_RDATA, d[i]); chk("t4_drain_resp", BUS_RRESP, r[i]);
         step();
      end
      @(negedge ACLK); chk("t4_drained", BUS_RVALID, 0);
      step();

      // AR backpressure
      ARREADY = 1'b0; BUS_ENA = 1'b1; BUS_ADDR = 32'h200;
      @(negedge ACLK); chk("t3_first_ack", BUS_ACK, 1);
      step(); BUS_ADDR = 32'h204;
      repeat (5) begin
         @(negedge ACLK);
         chk("t3_hold_valid", ARVALID, 1); chk("t3_hold_addr", ARADDR, 32'h200);
         chk("t3_hold_no_ack", BUS_ACK, 0);
         step();
      end
      ARREADY = 1'b1;
      @(negedge ACLK); chk("t3_ack_same_cycle", BUS_ACK, 1); chk("t3_addr_old", ARADDR, 32'h200);
      step(); BUS_ENA = 1'b0;
      @(negedge ACLK); chk("t3_addr_new", ARADDR, 32'h204); chk("t3_valid_new", ARVALID, 1);
      step(); RVALID = 1'b1; RDATA = 32'hA5A5_0001; RRESP = 2'b00;
      step(); RDATA = 32'hA5A5_0002;
      step(); RVALID = 1'b0;
      repeat (4) step();

      // reset with two reads outstanding
      BUS_ENA = 1'b1; BUS_ADDR = 32'h300;
      step(); BUS_ADDR = 32'h304;
      step(); BUS_ENA = 1'b0;
      step();
      ARESETn = 1'b0; BUS_ENA = 1'b1;
      #1;
      chk("t6_arvalid", ARVALID, 0); chk("t6_araddr", ARADDR, 0); chk("t6_rready", RREADY, 0);
      chk("t6_bus_ack", BUS_ACK, 0); chk("t6_bus_rvalid", BUS_RVALID, 0);
      step(); step();
      ARESETn = 1'b1; BUS_ENA = 1'b0; RVALID = 1'b1; RDATA = 32'hDEAD_0000;
      @(negedge ACLK); chk("t6_rready_after", RREADY, 0);
      step(); step(); RVALID = 1'b0;
      @(negedge ACLK); chk("t6_stray_ignored", BUS_RVALID, 0);
      step(); BUS_ENA = 1'b1; BUS_ADDR = 32'h400;
      step(); BUS_ENA = 1'b0;
      step(); RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b01;
      step(); RVALID = 1'b0;
      @(negedge ACLK); chk("t6_new_valid", BUS_RVALID, 1); chk("t6_new_data", BUS_RDATA, 32'h1234_5678);
      chk("t6_new_resp", BUS_RRESP, 2'b01);
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
